// File: rtl/mac_accum.sv
// Streaming signed multiply-accumulate with saturation; emits one wide result per frame.
// Optional macro MAC_ACCUM_OVF_FLAG_EN enables the sticky per-frame saturation flag on m_ovf.
module mac_accum #(
  parameter int W      = 24,
  parameter int ACCW   = 48,
  parameter int MAXLEN = 256,
  localparam int CW    = $clog2(MAXLEN) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [W-1:0]    s_a,
  input  logic signed [W-1:0]    s_b,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [ACCW-1:0] m_data,
  output logic [CW-1:0]          m_count,
  output logic                   m_ovf
);

  typedef enum logic [1:0] {st_acc, st_drain, st_hold} state_t;

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg;
  logic [CW-1:0]          cnt_inc;
  logic signed [2*W-1:0]  p_reg;
  logic                   p_vld_reg;
  logic                   p_last_reg;
  logic signed [ACCW-1:0] acc_reg;
  logic signed [ACCW-1:0] acc_next;
  logic signed [ACCW-1:0] p_ext;
  logic signed [ACCW:0]   sum;
  logic                   sat_ovf;
  logic                   accept;
  logic                   close_beat;
  logic                   emit;
  logic                   m_valid_reg;
  logic signed [ACCW-1:0] m_data_reg;
  logic [CW-1:0]          m_count_reg;

  assign accept     = s_valid & s_ready;
  assign cnt_inc    = cnt_reg + 1'b1;
  assign close_beat = s_last | (cnt_inc == CW'(MAXLEN));

  // One guard bit above the accumulator exposes signed overflow as sum[ACCW] != sum[ACCW-1].
  assign p_ext   = ACCW'(p_reg);
  assign sum     = {acc_reg[ACCW-1], acc_reg} + {p_ext[ACCW-1], p_ext};
  assign sat_ovf = p_vld_reg & (sum[ACCW] ^ sum[ACCW-1]);

  always_comb begin
    acc_next = acc_reg;
    if (p_vld_reg) begin
      if (sat_ovf) acc_next = sum[ACCW] ? ACC_MIN : ACC_MAX;
      else         acc_next = sum[ACCW-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    emit       = 1'b0;
    case (state_reg)
      st_acc: begin
        s_ready = ~rst;
        if (accept && close_beat) state_next = st_drain;
      end
      st_drain: begin
        if (p_vld_reg && p_last_reg) begin
          emit       = 1'b1;
          state_next = st_hold;
        end
      end
      st_hold: begin
        if (m_ready) state_next = st_acc;
      end
      default: state_next = st_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= st_acc;
      cnt_reg     <= '0;
      p_reg       <= '0;
      p_vld_reg   <= 1'b0;
      p_last_reg  <= 1'b0;
      acc_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      p_vld_reg <= accept;
      if (accept) begin
        p_reg      <= (2*W)'(s_a) * (2*W)'(s_b);
        p_last_reg <= close_beat;
        cnt_reg    <= cnt_inc;
      end
      if (emit) begin
        // The final product folds straight into the result; the frame state restarts.
        m_data_reg  <= acc_next;
        m_count_reg <= cnt_reg;
        m_valid_reg <= 1'b1;
        acc_reg     <= '0;
        cnt_reg     <= '0;
      end else begin
        acc_reg <= acc_next;
      end
      if (state_reg == st_hold && m_ready) m_valid_reg <= 1'b0;
    end
  end

`ifdef MAC_ACCUM_OVF_FLAG_EN
  logic ovf_reg;
  logic m_ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg   <= 1'b0;
      m_ovf_reg <= 1'b0;
    end else if (emit) begin
      m_ovf_reg <= ovf_reg | sat_ovf;
      ovf_reg   <= 1'b0;
    end else if (sat_ovf) begin
      ovf_reg <= 1'b1;
    end
  end

  assign m_ovf = m_ovf_reg;
`else
  assign m_ovf = 1'b0;
`endif

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_count = m_count_reg;

endmodule
